// File: rtl/button_conditioner.sv
// Conditions five raw pushbuttons into single-cycle command pulses.
// Every button is synchronized and debounced. Set/left/right pulse once per
// press. Up/down pulse on press, then auto-repeat after an initial delay,
// and are locked out while both are held together.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_btn_set,
  input  logic i_btn_up,
  input  logic i_btn_down,
  input  logic i_btn_left,
  input  logic i_btn_right,
  output logic o_set,
  output logic o_up,
  output logic o_down,
  output logic o_left,
  output logic o_right
);

  localparam logic [19:0] DC_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] RD_LAST = 20'(REPEAT_DELAY - 1);
  localparam logic [19:0] RP_LAST = 20'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  // Button bit order: 0 set, 1 up, 2 down, 3 left, 4 right.
  logic [4:0]       w_raw;
  logic [4:0]       r_sync_p0;
  logic [4:0]       r_sync_p1;
  logic [4:0]       r_deb;
  logic [4:0][19:0] r_cnt;
  logic [4:0]       w_hit;
  logic [4:0]       w_deb_nxt;
  logic [4:0]       w_rise;
  logic             w_lock;

  // Up/down repeat engines: index 0 is up, index 1 is down.
  state_t           r_state [2];
  logic [1:0][19:0] r_tmr;
  logic [1:0]       r_rep;
  logic             r_set;
  logic             r_left;
  logic             r_right;

  assign w_raw = {i_btn_right, i_btn_left, i_btn_down, i_btn_up, i_btn_set};

  // Two-flop synchronizer; r_sync_p1 is the synchronized level.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // A debounced level flips on the edge where the disagreement has lasted long enough.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < 5; i++) begin
      w_hit[i] = (r_sync_p1[i] != r_deb[i]) && (r_cnt[i] == DC_LAST);
    end
  end

  assign w_deb_nxt = (r_deb & ~w_hit) | (r_sync_p1 & w_hit);
  assign w_rise    = w_hit & r_sync_p1;
  // Lockout is evaluated on next-state levels so it covers the edge where the
  // second button's debounced level rises.
  assign w_lock    = w_deb_nxt[1] & w_deb_nxt[2];

  // Debounce counters: count while synchronized and debounced levels disagree.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      r_deb <= w_deb_nxt;
      for (int i = 0; i < 5; i++) begin
        if ((r_sync_p1[i] == r_deb[i]) || w_hit[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Single-shot press pulses for set, left and right.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_set   <= 1'b0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      r_set   <= w_rise[0];
      r_left  <= w_rise[3];
      r_right <= w_rise[4];
    end
  end

  // Up/down auto-repeat FSMs with mutual lockout.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int j = 0; j < 2; j++) begin
        r_state[j] <= ST_IDLE;
      end
      r_tmr <= '0;
      r_rep <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        r_rep[j] <= 1'b0;
        if (!w_deb_nxt[j+1] || w_lock) begin
          r_state[j] <= ST_IDLE;
          r_tmr[j]   <= '0;
        end else begin
          case (r_state[j])
            ST_IDLE: begin
              // Only a fresh press arms the engine; a button still held after
              // lockout stays here until released and pressed again.
              if (w_rise[j+1]) begin
                r_rep[j]   <= 1'b1;
                r_tmr[j]   <= '0;
                r_state[j] <= ST_DELAY;
              end
            end
            ST_DELAY: begin
              if (r_tmr[j] == RD_LAST) begin
                r_rep[j]   <= 1'b1;
                r_tmr[j]   <= '0;
                r_state[j] <= ST_REPEAT;
              end else begin
                r_tmr[j] <= r_tmr[j] + 20'd1;
              end
            end
            ST_REPEAT: begin
              if (r_tmr[j] == RP_LAST) begin
                r_rep[j] <= 1'b1;
                r_tmr[j] <= '0;
              end else begin
                r_tmr[j] <= r_tmr[j] + 20'd1;
              end
            end
            default: begin
              r_state[j] <= ST_IDLE;
              r_tmr[j]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign o_set   = r_set;
  assign o_up    = r_rep[0];
  assign o_down  = r_rep[1];
  assign o_left  = r_left;
  assign o_right = r_right;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a behavioural model predicts the
// output vector after every rising edge, and a monitor compares on the
// falling edge.
module tb_button_conditioner;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] btn;
  logic       o_set, o_up, o_down, o_left, o_right;
  logic [4:0] dut_o;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_btn_set  (btn[0]),
    .i_btn_up   (btn[1]),
    .i_btn_down (btn[2]),
    .i_btn_left (btn[3]),
    .i_btn_right(btn[4]),
    .o_set      (o_set),
    .o_up       (o_up),
    .o_down     (o_down),
    .o_left     (o_left),
    .o_right    (o_right)
  );

  assign dut_o = {o_right, o_left, o_down, o_up, o_set};

  logic [4:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int mon_n    = 0;

  // Behavioural model: raw level seen two edges late, a debounced level that
  // follows a run of DC equal disagreeing samples, and up/down pulses defined
  // by how long the button has been held since an unlocked press.
  logic [4:0] m_s1, m_s2, m_d;
  int         m_run [5];
  bit         m_armed [2];
  int         m_age [2];

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_d  = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    for (int k = 0; k < 2; k++) begin
      m_armed[k] = 1'b0;
      m_age[k]   = 0;
    end
  endtask

  task automatic model_step(output logic [4:0] e);
    logic [4:0] old_d;
    logic [4:0] rose;
    logic       lock;
    e = '0;
    if (!rstn) begin
      model_reset();
      return;
    end
    old_d = m_d;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] != m_d[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_d[i]   = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
    rose = m_d & ~old_d;
    e[0] = rose[0];
    e[3] = rose[3];
    e[4] = rose[4];
    lock = m_d[1] & m_d[2];
    for (int k = 0; k < 2; k++) begin
      if (rose[k+1] && !lock) begin
        m_armed[k] = 1'b1;
        m_age[k]   = 0;
        e[k+1]     = 1'b1;
      end else if (m_d[k+1] && m_armed[k] && !lock) begin
        m_age[k]++;
        e[k+1] = (m_age[k] == RD) || (m_age[k] > RD && ((m_age[k] - RD) % RP) == 0);
      end else begin
        m_armed[k] = 1'b0;
        m_age[k]   = 0;
      end
    end
  endtask

  // Advance n clocks; inputs may be changed by the caller 7ns after each edge.
  task automatic tick(input int n);
    logic [4:0] e;
    repeat (n) begin
      @(posedge clk);
      model_step(e);
      exp_q.push_back(e);
      edge_n++;
      #7;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Monitor: compares the DUT outputs against the predicted vector for each edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_n++;
        checks++;
        if (dut_o !== e) begin
          failures++;
          $display("FAIL outputs edge=%0d got=%b expected=%b (right,left,down,up,set)",
                   mon_n, dut_o, e);
        end
      end
    end
  end

  initial begin
    model_reset();
    rstn = 1'b0;
    btn  = '0;
    #1;
    check("reset_outputs", int'(dut_o), 0);
    tick(3);
    rstn = 1'b1;
    tick(5);

    // Set held: one pulse after the debounce window, none on release.
    btn = 5'b00001;
    tick(50);
    btn = '0;
    tick(10);

    // Short press glitch on left, then a short release glitch while held.
    btn = 5'b01000;
    tick(3);
    btn = '0;
    tick(10);
    btn = 5'b01000;
    tick(10);
    btn = '0;
    tick(2);
    btn = 5'b01000;
    tick(10);
    btn = '0;
    tick(10);

    // Up held: press pulse, delayed first repeat, then periodic repeats.
    btn = 5'b00010;
    tick(30);
    btn = '0;
    tick(10);

    // Up held, down joins: lockout, then up must be re-pressed.
    btn = 5'b00010;
    tick(20);
    btn = 5'b00110;
    tick(15);
    btn = 5'b00010;
    tick(20);
    btn = '0;
    tick(8);
    btn = 5'b00010;
    tick(20);
    btn = '0;
    tick(10);

    // Right held through a reset pulse; outputs clear immediately on reset.
    btn = 5'b10000;
    tick(4);
    rstn = 1'b0;
    #1;
    check("async_reset_outputs", int'(dut_o), 0);
    tick(2);
    rstn = 1'b1;
    tick(12);
    btn = '0;
    tick(10);

    // Reset in the middle of up auto-repeat.
    btn = 5'b00010;
    tick(20);
    rstn = 1'b0;
    #1;
    check("reset_mid_repeat", int'(dut_o), 0);
    tick(2);
    rstn = 1'b1;
    tick(20);
    btn = '0;
    tick(10);

    // Set, left and right together.
    btn = 5'b11001;
    tick(10);
    btn = '0;
    tick(10);

    // Randomized button activity with occasional resets.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        rstn = 1'b0;
        tick($urandom_range(1, 3));
        rstn = 1'b1;
      end
      btn = 5'($urandom);
      if ($urandom_range(0, 2) == 0) btn[2] = 1'b0;
      tick($urandom_range(1, 20));
    end
    btn = '0;
    tick(10);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("edges_compared", mon_n, edge_n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
